// File: rtl/vga_pkg.sv
// Shared 1280x800 display constants and the VRAM arbiter state encoding.
package vga_pkg;

   localparam int H_ACTIVE       = 1280;
   localparam int H_TOTAL        = 1440;
   localparam int V_ACTIVE       = 800;
   localparam int V_TOTAL        = 823;
   localparam int PIX_PER_WORD   = 2;
   localparam int VGA_LINE_WORDS = H_ACTIVE / PIX_PER_WORD;
   localparam int VGA_LINE_SHIFT = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BURST,
      ST_DRAIN
   } arb_state_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// Tracks in-flight SRAM reads: a DEPTH-deep {valid, index} shift register with squash.
module vram_rd_pipe #(
   parameter int DEPTH = 2,
   parameter int IDX_W = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             squash_i,
   input  logic             load_v_i,
   input  logic [IDX_W-1:0] load_idx_i,
   output logic             out_v_o,
   output logic [IDX_W-1:0] out_idx_o,
   output logic             pend_o
);

   localparam logic [DEPTH-1:0] LAST_MASK = DEPTH'(1) << (DEPTH - 1);

   logic [DEPTH-1:0] vld_q;
   logic [IDX_W-1:0] idx_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
      end else if (squash_i) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= load_v_i;
         for (int k = 1; k < DEPTH; k++) vld_q[k] <= vld_q[k-1];
      end
   end

   always_ff @(posedge clk_i) begin
      idx_q[0] <= load_idx_i;
      for (int k = 1; k < DEPTH; k++) idx_q[k] <= idx_q[k-1];
   end

   assign out_v_o   = vld_q[DEPTH-1];
   assign out_idx_o = idx_q[DEPTH-1];
   // Reads still behind the output stage; the one at the output retires this cycle.
   assign pend_o    = |(vld_q & ~LAST_MASK);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel SRAM arbiter: display line prefetch has priority over host writes.
// Optional macro HOST_SLOT_EN grants the host one cycle every HOST_SLOT_PERIOD burst reads.
module vram_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int LINE_SHIFT = VGA_LINE_SHIFT,
   parameter int LINE_WORDS = VGA_LINE_WORDS,
   parameter int READ_LAT   = 2
`ifdef HOST_SLOT_EN
   , parameter int HOST_SLOT_PERIOD = 16
`endif
) (
   input  logic              pixel_clk,
   input  logic              rst_n,
   input  logic              fetch_start,
   input  logic [9:0]        fetch_row,
   output logic              fetch_busy,
   output logic              fetch_done,
   output logic              fetch_overrun,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lb_we,
   output logic [9:0]        lb_addr,
   output logic [DATA_W-1:0] lb_data
);

   localparam int               IDX_W    = 10;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, rd_idx_q;
   logic [ADDR_W-1:0] base_q, base_d, row_base, mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_en_q, mem_we_q;
   logic              issue_rd, issue_wr, grant_host, squash, slot_grant, rd_inflight;
   logic              pipe_v, pipe_pend;
   logic [IDX_W-1:0]  pipe_idx;

   assign row_base    = ADDR_W'(fetch_row) << LINE_SHIFT;
   assign rd_inflight = mem_en_q & ~mem_we_q;

`ifdef HOST_SLOT_EN
   localparam int SLOT_W = $clog2(HOST_SLOT_PERIOD + 1);
   logic [SLOT_W-1:0] slot_q;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q <= '0;
      end else if (fetch_start) begin
         slot_q <= '0;
      end else if (issue_rd) begin
         // A slot skipped for lack of a host request still starts the next period.
         slot_q <= (slot_q == SLOT_W'(HOST_SLOT_PERIOD)) ? SLOT_W'(1) : slot_q + 1'b1;
      end else if (issue_wr && state_q != ST_IDLE) begin
         slot_q <= '0;
      end
   end

   assign slot_grant = (slot_q == SLOT_W'(HOST_SLOT_PERIOD)) && host_wr_valid;
`else
   assign slot_grant = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      base_d     = base_q;
      issue_rd   = 1'b0;
      grant_host = 1'b0;
      squash     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fetch_start) begin
               state_d = ST_BURST;
               base_d  = row_base;
               idx_d   = '0;
            end else begin
               grant_host = 1'b1;
            end
         end
         ST_BURST: begin
            if (fetch_start) begin
               squash = 1'b1;
               base_d = row_base;
               idx_d  = '0;
            end else if (slot_grant) begin
               grant_host = 1'b1;
            end else begin
               issue_rd = 1'b1;
               idx_d    = idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fetch_start) begin
               squash  = 1'b1;
               state_d = ST_BURST;
               base_d  = row_base;
               idx_d   = '0;
            end else begin
               grant_host = slot_grant;
               if (!rd_inflight && !pipe_pend) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign issue_wr = grant_host & host_wr_valid;

   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         base_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         base_q   <= base_d;
         mem_en_q <= issue_rd | issue_wr;
         mem_we_q <= issue_wr;
         if (issue_wr) begin
            mem_addr_q  <= host_addr;
            mem_wdata_q <= host_data;
         end else if (issue_rd) begin
            mem_addr_q <= base_q + ADDR_W'(idx_q);
         end
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (issue_rd) rd_idx_q <= idx_q;
   end

   vram_rd_pipe #(
      .DEPTH (READ_LAT),
      .IDX_W (IDX_W)
   ) u_rd_pipe (
      .clk_i      (pixel_clk),
      .rst_ni     (rst_n),
      .squash_i   (squash),
      .load_v_i   (rd_inflight),
      .load_idx_i (rd_idx_q),
      .out_v_o    (pipe_v),
      .out_idx_o  (pipe_idx),
      .pend_o     (pipe_pend)
   );

   assign mem_en        = mem_en_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign lb_we         = pipe_v;
   assign lb_addr       = pipe_v ? pipe_idx : '0;
   assign lb_data       = pipe_v ? mem_rdata : '0;
   assign fetch_done    = pipe_v && (pipe_idx == LAST_IDX);
   assign fetch_busy    = (state_q != ST_IDLE);
   assign fetch_overrun = fetch_start && (state_q != ST_IDLE);
   assign host_wr_ready = grant_host & rst_n;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: SRAM model with 2-cycle read latency and line-buffer scoreboard.
module tb_vram_arbiter;

   logic        pixel_clk = 1'b0;
   logic        rst_n, fetch_start, host_wr_valid;
   logic [9:0]  fetch_row;
   logic [17:0] host_addr, mem_addr;
   logic [15:0] host_data, mem_wdata, mem_rdata, lb_data;
   logic        fetch_busy, fetch_done, fetch_overrun, host_wr_ready;
   logic        mem_en, mem_we, lb_we;
   logic [9:0]  lb_addr;

   int checks = 0, errors = 0, sb_checks = 0, sb_errors = 0, done_cnt = 0;
   logic [25:0] exp_q [$];
   logic [25:0] sb_exp;
   logic        rd_v1;
   logic [17:0] rd_a1;

   vram_arbiter dut (
      .pixel_clk     (pixel_clk),
      .rst_n         (rst_n),
      .fetch_start   (fetch_start),
      .fetch_row     (fetch_row),
      .fetch_busy    (fetch_busy),
      .fetch_done    (fetch_done),
      .fetch_overrun (fetch_overrun),
      .host_wr_valid (host_wr_valid),
      .host_wr_ready (host_wr_ready),
      .host_addr     (host_addr),
      .host_data     (host_data),
      .mem_en        (mem_en),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .lb_we         (lb_we),
      .lb_addr       (lb_addr),
      .lb_data       (lb_data)
   );

   always #5 pixel_clk = ~pixel_clk;

   function automatic logic [15:0] mem_word(input logic [17:0] a);
      return a[15:0] ^ 16'h5A5A ^ {14'd0, a[17:16]};
   endfunction

   // SRAM model: data valid two cycles after the mem_en cycle.
   always @(posedge pixel_clk) begin
      rd_v1     <= mem_en && !mem_we;
      rd_a1     <= mem_addr;
      mem_rdata <= rd_v1 ? mem_word(rd_a1) : 16'h0000;
   end

   always @(negedge pixel_clk) begin
      if (lb_we) begin
         sb_checks++;
         if (exp_q.size() == 0) begin
            sb_errors++;
            $display("FAIL sb_unexpected: lb_addr=%0d lb_data=%h, no write expected", lb_addr, lb_data);
         end else begin
            sb_exp = exp_q.pop_front();
            if ({lb_addr, lb_data} !== sb_exp) begin
               sb_errors++;
               $display("FAIL sb_lb: got addr=%0d data=%h, want addr=%0d data=%h",
                        lb_addr, lb_data, sb_exp[25:16], sb_exp[15:0]);
            end
         end
      end
      sb_checks++;
      if (fetch_done !== (lb_we && lb_addr == 10'd639)) begin
         sb_errors++;
         $display("FAIL sb_done: fetch_done=%b lb_we=%b lb_addr=%0d", fetch_done, lb_we, lb_addr);
      end
      if (fetch_done === 1'b1) done_cnt++;
   end

   task automatic push_line(input logic [9:0] row, input int n);
      logic [17:0] base;
      base = 18'(row) << 10;
      for (int i = 0; i < n; i++) exp_q.push_back({10'(i), mem_word(base + 18'(i))});
   endtask

   task automatic wait_done(input int limit, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < limit) begin
         @(negedge pixel_clk);
         #1;
         if (fetch_done === 1'b1) seen = 1'b1;
         else cycles++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge pixel_clk);
      host_wr_valid = 1'b1;
      #1;
      checks++;
      if ({mem_en, mem_we, fetch_busy, fetch_done, fetch_overrun, host_wr_ready, lb_we} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000000",
                  {mem_en, mem_we, fetch_busy, fetch_done, fetch_overrun, host_wr_ready, lb_we});
      end
      checks++;
      if (mem_addr !== 18'd0 || mem_wdata !== 16'd0 || lb_addr !== 10'd0 || lb_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: mem_addr=%h mem_wdata=%h lb_addr=%h lb_data=%h want all 0",
                  mem_addr, mem_wdata, lb_addr, lb_data);
      end
      host_wr_valid = 1'b0;
      @(negedge pixel_clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (host_wr_ready !== 1'b1 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: ready=%b busy=%b want 1/0", host_wr_ready, fetch_busy);
      end
   endtask

   task automatic test_host_write;
      @(negedge pixel_clk);
      host_wr_valid = 1'b1;
      host_addr     = 18'h01234;
      host_data     = 16'hBEEF;
      #1;
      checks++;
      if (host_wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL host_ready: got %b want 1", host_wr_ready);
      end
      @(negedge pixel_clk);
      host_wr_valid = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 18'h01234 || mem_wdata !== 16'hBEEF) begin
         errors++;
         $display("FAIL host_wr: en=%b we=%b addr=%h data=%h want 1/1/01234/beef",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge pixel_clk);
         if (k > 0) begin
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 18'h02000 + 18'(k - 1) ||
                mem_wdata !== 16'h3000 + 16'(k - 1)) begin
               errors++;
               $display("FAIL host_b2b%0d: en=%b we=%b addr=%h data=%h want 1/1/%h/%h", k, mem_en,
                        mem_we, mem_addr, mem_wdata, 18'h02000 + 18'(k - 1), 16'h3000 + 16'(k - 1));
            end
         end
         host_wr_valid = (k < 3);
         host_addr     = 18'h02000 + 18'(k);
         host_data     = 16'h3000 + 16'(k);
      end
      @(negedge pixel_clk);
      checks++;
      if (mem_en !== 1'b0) begin
         errors++;
         $display("FAIL host_idle: mem_en=%b want 0", mem_en);
      end
   endtask

   task automatic test_burst;
      int  cyc;
      bit  seen;
      @(negedge pixel_clk);
      fetch_row   = 10'd3;
      fetch_start = 1'b1;
      push_line(10'd3, 640);
      #1;
      checks++;
      if (fetch_busy !== 1'b0 || host_wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL burst_start: busy=%b ready=%b want 0/0", fetch_busy, host_wr_ready);
      end
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      checks++;
      if (fetch_busy !== 1'b1 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL burst_lat: busy=%b mem_en=%b want 1/0", fetch_busy, mem_en);
      end
      for (int i = 0; i < 640; i++) begin
         @(negedge pixel_clk);
         checks++;
         if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 18'h00C00 + 18'(i)) begin
            errors++;
            $display("FAIL burst_rd%0d: en=%b we=%b addr=%h want 1/0/%h", i, mem_en, mem_we,
                     mem_addr, 18'h00C00 + 18'(i));
         end
         if (i == 1 || i == 2) begin
            checks++;
            if (lb_we !== (i == 2) || (i == 2 && lb_addr !== 10'd0)) begin
               errors++;
               $display("FAIL burst_lbfirst%0d: lb_we=%b lb_addr=%0d", i, lb_we, lb_addr);
            end
         end
      end
      wait_done(8, cyc, seen);
      checks++;
      if (!seen || cyc != 1) begin
         errors++;
         $display("FAIL burst_done: seen=%b after %0d cycles, want seen after 1", seen, cyc);
      end
      @(negedge pixel_clk);
      #1;
      checks++;
      if (fetch_busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst_end: busy=%b pending=%0d want 0/0", fetch_busy, exp_q.size());
      end
   endtask

   task automatic test_collision;
      int k, bad_we, d0;
      bit seen;
      d0 = done_cnt;
      @(negedge pixel_clk);
      fetch_row     = 10'd7;
      fetch_start   = 1'b1;
      host_wr_valid = 1'b1;
      host_addr     = 18'h00AAA;
      host_data     = 16'h1111;
      push_line(10'd7, 640);
      #1;
      checks++;
      if (host_wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL coll_ready: got %b want 0", host_wr_ready);
      end
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      k = 1; bad_we = 0; seen = 1'b0;
      while (!seen && k < 800) begin
         #1;
         if (host_wr_ready === 1'b1) seen = 1'b1;
         else begin
            if (mem_we !== 1'b0) bad_we++;
            @(negedge pixel_clk);
            k++;
         end
      end
      checks++;
      if (!seen || k != 644 || bad_we != 0 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL coll_wait: seen=%b at cycle %0d (want 644) early_writes=%0d busy=%b",
                  seen, k, bad_we, fetch_busy);
      end
      @(negedge pixel_clk);
      host_wr_valid = 1'b0;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 18'h00AAA || mem_wdata !== 16'h1111 ||
          done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL coll_wr: en=%b we=%b addr=%h data=%h dones=%0d want 1/1/00aaa/1111/1",
                  mem_en, mem_we, mem_addr, mem_wdata, done_cnt - d0);
      end
   endtask

   task automatic test_overrun;
      int k, d0, cyc;
      bit found, seen;
      d0 = done_cnt;
      @(negedge pixel_clk);
      fetch_row   = 10'd3;
      fetch_start = 1'b1;
      push_line(10'd3, 99);
      push_line(10'd5, 640);
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      found = 1'b0; k = 0;
      while (!found && k < 200) begin
         @(negedge pixel_clk);
         if (mem_en === 1'b1 && mem_addr === 18'h00C64) found = 1'b1;
         k++;
      end
      if (!found) begin
         $display("FAIL ovr_reach: read index 100 not seen within 200 cycles");
         $fatal(1, "overrun stimulus could not be placed");
      end
      #2;
      fetch_row   = 10'd5;
      fetch_start = 1'b1;
      #1;
      checks++;
      if (fetch_overrun !== 1'b1 || fetch_busy !== 1'b1 || host_wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL ovr_pulse: overrun=%b busy=%b ready=%b want 1/1/0", fetch_overrun,
                  fetch_busy, host_wr_ready);
      end
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      #1;
      checks++;
      if (fetch_overrun !== 1'b0 || mem_en !== 1'b0) begin
         errors++;
         $display("FAIL ovr_gap: overrun=%b mem_en=%b want 0/0", fetch_overrun, mem_en);
      end
      @(negedge pixel_clk);
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 18'h01400) begin
         errors++;
         $display("FAIL ovr_restart: en=%b addr=%h want 1/01400", mem_en, mem_addr);
      end
      wait_done(700, cyc, seen);
      @(negedge pixel_clk);
      #1;
      checks++;
      if (!seen || fetch_busy !== 1'b0 || exp_q.size() != 0 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL ovr_end: seen=%b busy=%b pending=%0d dones=%0d want 1/0/0/1", seen,
                  fetch_busy, exp_q.size(), done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid;
      int k, d0, stray, cyc;
      bit found, seen;
      d0 = done_cnt;
      @(negedge pixel_clk);
      fetch_row   = 10'd3;
      fetch_start = 1'b1;
      push_line(10'd3, 299);
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      found = 1'b0; k = 0;
      while (!found && k < 400) begin
         @(negedge pixel_clk);
         if (mem_en === 1'b1 && mem_addr === 18'h00D2C) found = 1'b1;
         k++;
      end
      if (!found) begin
         $display("FAIL rstmid_reach: read index 300 not seen within 400 cycles");
         $fatal(1, "reset stimulus could not be placed");
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_en, mem_we, fetch_busy, fetch_done, lb_we, host_wr_ready} !== 6'b0 ||
          mem_addr !== 18'd0 || lb_addr !== 10'd0) begin
         errors++;
         $display("FAIL rstmid_async: ctrl=%b mem_addr=%h lb_addr=%h want all 0",
                  {mem_en, mem_we, fetch_busy, fetch_done, lb_we, host_wr_ready}, mem_addr, lb_addr);
      end
      repeat (2) @(negedge pixel_clk);
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pixel_clk);
         #1;
         if (lb_we !== 1'b0 || mem_en !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rstmid_quiet: stray cycles=%0d pending=%0d want 0/0", stray, exp_q.size());
      end
      @(negedge pixel_clk);
      fetch_row   = 10'd2;
      fetch_start = 1'b1;
      push_line(10'd2, 640);
      @(negedge pixel_clk);
      fetch_start = 1'b0;
      @(negedge pixel_clk);
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 18'h00800) begin
         errors++;
         $display("FAIL rstmid_fresh: en=%b addr=%h want 1/00800", mem_en, mem_addr);
      end
      wait_done(700, cyc, seen);
      @(negedge pixel_clk);
      #1;
      checks++;
      if (!seen || fetch_busy !== 1'b0 || exp_q.size() != 0 || done_cnt != d0 + 1) begin
         errors++;
         $display("FAIL rstmid_end: seen=%b busy=%b pending=%0d dones=%0d want 1/0/0/1", seen,
                  fetch_busy, exp_q.size(), done_cnt - d0);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      fetch_start   = 1'b0;
      fetch_row     = 10'd0;
      host_wr_valid = 1'b0;
      host_addr     = 18'd0;
      host_data     = 16'd0;
      test_reset;
      test_host_write;
      test_burst;
      test_collision;
      test_overrun;
      test_reset_mid;
      repeat (2) @(negedge pixel_clk);
      #1;
      errors += sb_errors;
      checks += sb_checks;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
